// File: rtl/ddr3_dfi_resp.sv
// DDR3 DFI responder: decodes DFI commands, tracks open banks and answers BL8 bursts from a small storage array.
// Optional byte-mask writes are enabled by defining DFI_RESP_MASK_EN.
module ddr3_dfi_resp #(
    parameter int DFI_DATA_WIDTH = 32,
    parameter int DDR_ROW_BITS   = 13,
    parameter int PHY_RD_LATENCY = 5,
    parameter int MEM_BANK_BITS  = 1,
    parameter int MEM_ROW_BITS   = 2,
    parameter int MEM_COL_BITS   = 3
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        dfi_rst_ni,
    input  logic                        dfi_cke_i,
    input  logic                        dfi_cs_ni,
    input  logic                        dfi_ras_ni,
    input  logic                        dfi_cas_ni,
    input  logic                        dfi_we_ni,
    input  logic                        dfi_odt_i,
    input  logic [2:0]                  dfi_bank_i,
    input  logic [DDR_ROW_BITS-1:0]     dfi_addr_i,
    input  logic                        dfi_wren_i,
    input  logic [DFI_DATA_WIDTH/8-1:0] dfi_mask_i,
    input  logic [DFI_DATA_WIDTH-1:0]   dfi_data_i,
    input  logic                        dfi_rden_i,
    output logic                        dfi_valid_o,
    output logic [DFI_DATA_WIDTH-1:0]   dfi_data_o,
    input  logic                        err_clr_i,
    output logic [3:0]                  err_o
);

    localparam int BASE_W = MEM_BANK_BITS + MEM_ROW_BITS + MEM_COL_BITS;
    localparam int IDX_W  = BASE_W + 2;
    localparam int DEPTH  = 1 << IDX_W;
    localparam int NBYTE  = DFI_DATA_WIDTH / 8;
    localparam int PIPE_N = PHY_RD_LATENCY - 1;

    logic                    cmd_en;
    logic [2:0]              cmd;
    logic                    is_rd, is_wr, is_act, is_pre, is_ref, is_mrs;
    logic [7:0]              bank_open;
    logic [DDR_ROW_BITS-1:0] bank_row [8];
    logic                    sel_open;
    logic [DDR_ROW_BITS-1:0] sel_row;
    logic [BASE_W-1:0]       cmd_base;

    logic [BASE_W-1:0]       wf_base [2];
    logic                    wf_rp, wf_wp;
    logic [1:0]              wf_cnt;
    logic [1:0]              wr_beat;
    logic                    wr_ok, wr_err_closed, wr_err_full;
    logic                    beat_ok, beat_err, wf_pop;

    logic [1:0]              rd_gap;
    logic                    rd_ok, rd_err;
    logic                    pipe_v    [PIPE_N];
    logic [BASE_W-1:0]       pipe_base [PIPE_N];
    logic                    burst_act;
    logic [1:0]              rd_beat;
    logic [BASE_W-1:0]       cur_base;

    logic [DFI_DATA_WIDTH-1:0] mem [DEPTH];
    logic [3:0]              err_new;

    assign cmd_en = dfi_cke_i & dfi_rst_ni & ~dfi_cs_ni;
    assign cmd    = {dfi_ras_ni, dfi_cas_ni, dfi_we_ni};
    assign is_rd  = cmd_en && (cmd == 3'b101);
    assign is_wr  = cmd_en && (cmd == 3'b100);
    assign is_act = cmd_en && (cmd == 3'b011);
    assign is_pre = cmd_en && (cmd == 3'b010);
    assign is_ref = cmd_en && (cmd == 3'b001);
    assign is_mrs = cmd_en && (cmd == 3'b000);

    assign sel_open = bank_open[dfi_bank_i];
    assign sel_row  = bank_row[dfi_bank_i];
    assign cmd_base = {dfi_bank_i[MEM_BANK_BITS-1:0], sel_row[MEM_ROW_BITS-1:0],
                       dfi_addr_i[MEM_COL_BITS+2:3]};

    // rd_gap is a down-counter enforcing the 4-cycle minimum between accepted reads
    assign rd_ok  = is_rd & sel_open & (rd_gap == 2'd0);
    assign rd_err = is_rd & ~rd_ok;

    assign wr_ok         = is_wr & sel_open & (wf_cnt != 2'd2);
    assign wr_err_closed = is_wr & ~sel_open;
    assign wr_err_full   = is_wr & sel_open & (wf_cnt == 2'd2);
    assign beat_ok       = dfi_wren_i & dfi_rst_ni & (wf_cnt != 2'd0);
    assign beat_err      = dfi_wren_i & dfi_rst_ni & (wf_cnt == 2'd0);
    assign wf_pop        = beat_ok & (wr_beat == 2'd3);

    assign err_new = {(is_ref | is_mrs) & (|bank_open),
                      beat_err | wr_err_full,
                      rd_err | wr_err_closed,
                      is_act & sel_open};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_open <= '0;
            for (int i = 0; i < 8; i++) bank_row[i] <= '0;
        end else if (!dfi_rst_ni) begin
            bank_open <= '0;
        end else if (is_act) begin
            bank_open[dfi_bank_i] <= 1'b1;
            bank_row[dfi_bank_i]  <= dfi_addr_i;
        end else if (is_pre) begin
            if (dfi_addr_i[10]) bank_open <= '0;
            else                bank_open[dfi_bank_i] <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wf_base[0] <= '0;
            wf_base[1] <= '0;
            wf_rp      <= 1'b0;
            wf_wp      <= 1'b0;
            wf_cnt     <= 2'd0;
            wr_beat    <= 2'd0;
        end else if (!dfi_rst_ni) begin
            wf_rp   <= 1'b0;
            wf_wp   <= 1'b0;
            wf_cnt  <= 2'd0;
            wr_beat <= 2'd0;
        end else begin
            if (wr_ok) begin
                wf_base[wf_wp] <= cmd_base;
                wf_wp          <= ~wf_wp;
            end
            if (beat_ok) wr_beat <= wr_beat + 2'd1;
            if (wf_pop)  wf_rp   <= ~wf_rp;
            wf_cnt <= wf_cnt + 2'(wr_ok) - 2'(wf_pop);
        end
    end

    // storage keeps its contents across reset
    always_ff @(posedge clock) begin
        if (beat_ok) begin
            for (int b = 0; b < NBYTE; b++) begin
`ifdef DFI_RESP_MASK_EN
                if (!dfi_mask_i[b])
                    mem[{wf_base[wf_rp], wr_beat}][b*8 +: 8] <= dfi_data_i[b*8 +: 8];
`else
                mem[{wf_base[wf_rp], wr_beat}][b*8 +: 8] <= dfi_data_i[b*8 +: 8];
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_gap      <= 2'd0;
            burst_act   <= 1'b0;
            rd_beat     <= 2'd0;
            cur_base    <= '0;
            dfi_valid_o <= 1'b0;
            dfi_data_o  <= '0;
            for (int i = 0; i < PIPE_N; i++) begin
                pipe_v[i]    <= 1'b0;
                pipe_base[i] <= '0;
            end
        end else if (!dfi_rst_ni) begin
            rd_gap      <= 2'd0;
            burst_act   <= 1'b0;
            rd_beat     <= 2'd0;
            dfi_valid_o <= 1'b0;
            dfi_data_o  <= '0;
            for (int i = 0; i < PIPE_N; i++) pipe_v[i] <= 1'b0;
        end else begin
            if (rd_ok)                 rd_gap <= 2'd3;
            else if (rd_gap != 2'd0)   rd_gap <= rd_gap - 2'd1;
            pipe_v[0]    <= rd_ok;
            pipe_base[0] <= cmd_base;
            for (int i = 1; i < PIPE_N; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_base[i] <= pipe_base[i-1];
            end
            // reads are at least 4 apart, so a new burst never overlaps the running one
            if (pipe_v[PIPE_N-1]) begin
                dfi_valid_o <= 1'b1;
                dfi_data_o  <= mem[{pipe_base[PIPE_N-1], 2'd0}];
                cur_base    <= pipe_base[PIPE_N-1];
                rd_beat     <= 2'd1;
                burst_act   <= 1'b1;
            end else if (burst_act) begin
                dfi_valid_o <= 1'b1;
                dfi_data_o  <= mem[{cur_base, rd_beat}];
                rd_beat     <= rd_beat + 2'd1;
                if (rd_beat == 2'd3) burst_act <= 1'b0;
            end else begin
                dfi_valid_o <= 1'b0;
                dfi_data_o  <= '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_o <= 4'd0;
        else          err_o <= (err_clr_i ? 4'd0 : err_o) | err_new;
    end

    // ODT, RDEN, upper row bits and (when unmasked) the mask carry no function here
    logic unused_sink;
    always_comb begin
        unused_sink = dfi_odt_i ^ dfi_rden_i;
        for (int i = 0; i < 8; i++)
            unused_sink = unused_sink ^ (^bank_row[i][DDR_ROW_BITS-1:MEM_ROW_BITS]);
`ifndef DFI_RESP_MASK_EN
        unused_sink = unused_sink ^ (^dfi_mask_i);
`endif
    end

endmodule

// File: tb/tb_ddr3_dfi_resp.sv
// Testbench for ddr3_dfi_resp: directed vector table, hand sequences and random traffic vs a queue-based model.
module tb_ddr3_dfi_resp;

    localparam int LAT = 5;
    localparam logic [3:0] C_NOP = 4'b0111, C_RD = 4'b0101, C_WR = 4'b0100, C_ACT = 4'b0011;
    localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000, C_ZQ = 4'b0110;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        dfi_rst_ni = 1'b1, dfi_cke_i = 1'b1;
    logic        dfi_cs_ni = 1'b0, dfi_ras_ni = 1'b1, dfi_cas_ni = 1'b1, dfi_we_ni = 1'b1;
    logic        dfi_odt_i = 1'b0, dfi_rden_i = 1'b0;
    logic [2:0]  dfi_bank_i = '0;
    logic [12:0] dfi_addr_i = '0;
    logic        dfi_wren_i = 1'b0;
    logic [3:0]  dfi_mask_i = '0;
    logic [31:0] dfi_data_i = '0;
    logic        dfi_valid_o;
    logic [31:0] dfi_data_o;
    logic        err_clr_i = 1'b0;
    logic [3:0]  err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    ddr3_dfi_resp dut (
        .clock(clock), .reset_n(reset_n), .dfi_rst_ni(dfi_rst_ni), .dfi_cke_i(dfi_cke_i),
        .dfi_cs_ni(dfi_cs_ni), .dfi_ras_ni(dfi_ras_ni), .dfi_cas_ni(dfi_cas_ni), .dfi_we_ni(dfi_we_ni),
        .dfi_odt_i(dfi_odt_i), .dfi_bank_i(dfi_bank_i), .dfi_addr_i(dfi_addr_i),
        .dfi_wren_i(dfi_wren_i), .dfi_mask_i(dfi_mask_i), .dfi_data_i(dfi_data_i),
        .dfi_rden_i(dfi_rden_i), .dfi_valid_o(dfi_valid_o), .dfi_data_o(dfi_data_o),
        .err_clr_i(err_clr_i), .err_o(err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int start; int base; } rd_t;
    bit          m_open [8];
    logic [12:0] m_row  [8];
    logic [31:0] m_mem  [256];
    logic [3:0]  m_known [256];
    int          wq[$];
    rd_t         rdq[$];
    int          m_beat;
    int          last_rd;
    int          edge_n = 0;
    logic [3:0]  m_err;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin m_open[i] = 0; m_row[i] = '0; end
        wq.delete(); rdq.delete();
        m_beat = 0; last_rd = -100; m_err = '0;
    endtask

    task automatic model_edge();
        bit exp_v; logic [31:0] exp_d; bit dchk; logic [3:0] det; logic [3:0] c;
        int sz0, b, base, idx; bit wr_push; bit any_open;
        exp_v = 0; exp_d = '0; dchk = 1; det = '0; wr_push = 0;
        if (!reset_n) begin
            model_reset();
        end else if (!dfi_rst_ni) begin
            for (int i = 0; i < 8; i++) m_open[i] = 0;
            wq.delete(); rdq.delete(); m_beat = 0; last_rd = -100;
        end else begin
            while (rdq.size() > 0 && rdq[0].start + 3 < edge_n) void'(rdq.pop_front());
            if (rdq.size() > 0 && rdq[0].start <= edge_n) begin
                idx = rdq[0].base * 4 + (edge_n - rdq[0].start);
                exp_v = 1; exp_d = m_mem[idx]; dchk = (m_known[idx] == 4'hF);
            end
            sz0 = wq.size();
            c = {dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni};
            b = int'(dfi_bank_i);
            base = (b % 2) * 32 + (int'(m_row[b]) % 4) * 8 + (int'(dfi_addr_i) / 8) % 8;
            any_open = 0;
            for (int i = 0; i < 8; i++) any_open |= m_open[i];
            if (dfi_cke_i && !c[3]) begin
                case (c)
                    C_ACT: begin if (m_open[b]) det[0] = 1; m_open[b] = 1; m_row[b] = dfi_addr_i; end
                    C_PRE: if (dfi_addr_i[10]) for (int i = 0; i < 8; i++) m_open[i] = 0;
                           else m_open[b] = 0;
                    C_REF, C_MRS: if (any_open) det[3] = 1;
                    C_RD: if (!m_open[b] || edge_n - last_rd < 4) det[1] = 1;
                          else begin rdq.push_back('{edge_n + LAT - 1, base}); last_rd = edge_n; end
                    C_WR: if (!m_open[b]) det[1] = 1;
                          else if (sz0 >= 2) det[2] = 1;
                          else wr_push = 1;
                    default: ;
                endcase
            end
            if (dfi_wren_i) begin
                if (sz0 == 0) det[2] = 1;
                else begin
                    idx = wq[0] * 4 + m_beat;
                    for (int k = 0; k < 4; k++) begin
`ifdef DFI_RESP_MASK_EN
                        if (!dfi_mask_i[k]) begin
`else
                        begin
`endif
                            m_mem[idx][k*8 +: 8] = dfi_data_i[k*8 +: 8];
                            m_known[idx][k] = 1'b1;
                        end
                    end
                    m_beat++;
                    if (m_beat == 4) begin m_beat = 0; void'(wq.pop_front()); end
                end
            end
            if (wr_push) wq.push_back(base);
        end
        if (reset_n) m_err = (err_clr_i ? 4'd0 : m_err) | det;
        edge_n++;
        chk("model_valid", {31'd0, dfi_valid_o}, {31'd0, exp_v});
        if (dchk) chk("model_data", dfi_data_o, exp_d);
        chk("model_err", {28'd0, err_o}, {28'd0, m_err});
    endtask

    task automatic step();
        @(posedge clock); #1;
        model_edge();
    endtask

    task automatic drive(input logic [3:0] c, input int b, input int a, input bit w,
                         input logic [31:0] d, input logic [3:0] m, input bit clr);
        {dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni} = c;
        dfi_bank_i = 3'(b); dfi_addr_i = 13'(a);
        dfi_wren_i = w; dfi_data_i = d; dfi_mask_i = m; err_clr_i = clr;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0] cmd; int bank; int addr; bit wren; logic [31:0] data; bit clr;
        bit exp_v; logic [31:0] exp_d; logic [3:0] exp_err;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [3:0] c, input int b, input int a, input bit w, input logic [31:0] d,
                       input bit clr, input bit ev, input logic [31:0] ed, input logic [3:0] ee);
        vec_t v;
        v.cmd = c; v.bank = b; v.addr = a; v.wren = w; v.data = d; v.clr = clr;
        v.exp_v = ev; v.exp_d = ed; v.exp_err = ee;
        tbl.push_back(v);
    endtask

    task automatic nop(input bit ev, input logic [31:0] ed, input logic [3:0] ee);
        add(C_NOP, 0, 0, 0, 0, 0, ev, ed, ee);
    endtask

    task automatic read_beats(input logic [31:0] ed, input logic [3:0] ee);
        for (int k = 0; k < 4; k++) nop(1, ed + 32'(k), ee);
    endtask

    logic [31:0] mask_exp;

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = '0;
        model_reset();
        step(); step();
        chk("reset_valid", {31'd0, dfi_valid_o}, 32'd0);
        chk("reset_data", dfi_data_o, 32'd0);
        chk("reset_err", {28'd0, err_o}, 32'd0);
        reset_n = 1'b1;

        // write then read back one burst
        add(C_ACT, 0, 1, 0, 0, 0, 0, 0, 4'h0);
        add(C_WR, 0, 8, 0, 0, 0, 0, 0, 4'h0);
        for (int k = 0; k < 4; k++) add(C_NOP, 0, 0, 1, 32'hA0 + 32'(k), 0, 0, 0, 4'h0);
        add(C_RD, 0, 8, 0, 0, 0, 0, 0, 4'h0);
        nop(0, 0, 4'h0); nop(0, 0, 4'h0); nop(0, 0, 4'h0);
        read_beats(32'hA0, 4'h0);
        nop(0, 0, 4'h0);
        // read of a closed bank, then clear
        add(C_RD, 2, 0, 0, 0, 0, 0, 0, 4'h2);
        nop(0, 0, 4'h2);
        add(C_NOP, 0, 0, 0, 0, 1, 0, 0, 4'h0);
        // double activate, precharge-all + refresh, refresh with open bank
        add(C_ACT, 1, 2, 0, 0, 0, 0, 0, 4'h0);
        add(C_ACT, 1, 3, 0, 0, 0, 0, 0, 4'h1);
        add(C_NOP, 0, 0, 0, 0, 1, 0, 0, 4'h0);
        add(C_PRE, 0, 13'h400, 0, 0, 0, 0, 0, 4'h0);
        add(C_REF, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        add(C_ACT, 1, 0, 0, 0, 0, 0, 0, 4'h0);
        add(C_REF, 0, 0, 0, 0, 0, 0, 0, 4'h8);
        add(C_NOP, 0, 0, 0, 0, 1, 0, 0, 4'h0);
        // reads 4 apart give 8 contiguous beats
        add(C_ACT, 0, 1, 0, 0, 0, 0, 0, 4'h0);
        add(C_RD, 0, 8, 0, 0, 0, 0, 0, 4'h0);
        nop(0, 0, 4'h0); nop(0, 0, 4'h0); nop(0, 0, 4'h0);
        add(C_RD, 0, 8, 0, 0, 0, 1, 32'hA0, 4'h0);
        nop(1, 32'hA1, 4'h0); nop(1, 32'hA2, 4'h0); nop(1, 32'hA3, 4'h0);
        read_beats(32'hA0, 4'h0);
        // reads 2 apart: second dropped
        add(C_RD, 0, 8, 0, 0, 0, 0, 0, 4'h0);
        nop(0, 0, 4'h0);
        add(C_RD, 0, 8, 0, 0, 0, 0, 0, 4'h2);
        nop(0, 0, 4'h2);
        read_beats(32'hA0, 4'h2);
        nop(0, 0, 4'h2); nop(0, 0, 4'h2);
        add(C_NOP, 0, 0, 0, 0, 1, 0, 0, 4'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].cmd, tbl[i].bank, tbl[i].addr, tbl[i].wren, tbl[i].data, 4'h0, tbl[i].clr);
            step();
            chk($sformatf("tbl%0d_valid", i), {31'd0, dfi_valid_o}, {31'd0, tbl[i].exp_v});
            chk($sformatf("tbl%0d_data", i), dfi_data_o, tbl[i].exp_d);
            chk($sformatf("tbl%0d_err", i), {28'd0, err_o}, {28'd0, tbl[i].exp_err});
        end

        // masked overwrite: mask bit 1 leaves that byte untouched
`ifdef DFI_RESP_MASK_EN
        mask_exp = 32'h1234FFFF;
`else
        mask_exp = 32'hFFFFFFFF;
`endif
        drive(C_WR, 0, 16, 0, 0, 0, 0); step();
        for (int k = 0; k < 4; k++) begin drive(C_NOP, 0, 0, 1, 32'h12345678, 4'h0, 0); step(); end
        drive(C_WR, 0, 16, 0, 0, 0, 0); step();
        for (int k = 0; k < 4; k++) begin drive(C_NOP, 0, 0, 1, 32'hFFFFFFFF, 4'b1100, 0); step(); end
        drive(C_RD, 0, 16, 0, 0, 0, 0); step();
        drive(C_NOP, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mask_valid", {31'd0, dfi_valid_o}, 32'd1);
            chk("mask_data", dfi_data_o, mask_exp);
        end

        // async reset during read beat 2
        drive(C_ACT, 0, 1, 0, 0, 0, 0); step();
        chk("act_open_err", {28'd0, err_o}, 32'd1);
        drive(C_RD, 0, 8, 0, 0, 0, 0); step();
        drive(C_NOP, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step();
        chk("rst_beat2_data", dfi_data_o, 32'hA2);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'd0, dfi_valid_o}, 32'd0);
        chk("rst_async_data", dfi_data_o, 32'd0);
        chk("rst_async_err", {28'd0, err_o}, 32'd0);
        model_reset();
        step(); step();
        reset_n = 1'b1;
        step();
        chk("rst_after_err", {28'd0, err_o}, 32'd0);
        drive(C_RD, 0, 8, 0, 0, 0, 0); step();
        chk("rst_bank_closed", {28'd0, err_o}, 32'd2);
        drive(C_NOP, 0, 0, 0, 0, 1, 0); step();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [3:0] c;
            r = $urandom_range(0, 99);
            if      (r < 15) c = C_ACT;
            else if (r < 25) c = C_PRE;
            else if (r < 45) c = C_RD;
            else if (r < 62) c = C_WR;
            else if (r < 64) c = C_REF;
            else if (r < 65) c = C_MRS;
            else if (r < 67) c = C_ZQ;
            else if (r < 69) c = 4'(8 + $urandom_range(0, 7));
            else             c = C_NOP;
            drive(c, $urandom_range(0, 3), $urandom_range(0, 8191), $urandom_range(0, 99) < 45,
                  $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0,
                  $urandom_range(0, 99) < 4);
            dfi_cke_i  = $urandom_range(0, 99) < 97;
            dfi_rst_ni = $urandom_range(0, 199) != 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
